// File: rtl/scratchstack_ctrl.sv
// Command/response sequencer for the single-port scratch-stack RAM.
// Owns the stack pointer and reports PUSH overflow and POP/PEEK underflow.
module scratchstack_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wen,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD1, S_RD2} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_sp;
    logic                  r_err;
    logic                  r_clr;
    logic [ADDR_WIDTH:0]   w_sp_dec;

    assign w_sp_dec  = r_sp - (ADDR_WIDTH+1)'(1);
    assign depth     = r_sp;
    assign empty     = (r_sp == '0);
    assign full      = (r_sp == CAP);
    assign cmd_ready = (r_state == S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_sp      <= '0;
            r_err     <= 1'b0;
            r_clr     <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wen   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_clr <= (cmd_op == OP_CLEAR);
                        if (cmd_op == OP_CLEAR) begin
                            r_err   <= 1'b0;
                            r_state <= S_WR;
                        end else if (cmd_op == OP_PUSH) begin
                            // overflow takes the same path as a write, minus the write
                            r_err   <= full;
                            r_state <= S_WR;
                            if (!full) begin
                                ram_addr  <= r_sp[ADDR_WIDTH-1:0];
                                ram_wdata <= cmd_wdata;
                                ram_wen   <= 1'b1;
                            end
                        end else begin
                            r_err   <= empty;
                            r_state <= S_RD1;
                            if (!empty) begin
                                ram_addr <= w_sp_dec[ADDR_WIDTH-1:0];
                                if (cmd_op == OP_POP) r_sp <= w_sp_dec;
                            end
                        end
                    end
                end
                S_WR: begin
                    ram_wen   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_err;
                    if (r_clr)       r_sp <= '0;
                    else if (!r_err) r_sp <= r_sp + (ADDR_WIDTH+1)'(1);
                    r_state   <= S_IDLE;
                end
                S_RD1: r_state <= S_RD2;
                S_RD2: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_err;
                    rsp_rdata <= r_err ? '0 : ram_rdata;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scratchstack_ctrl.sv
// Scoreboard bench for scratchstack_ctrl with a behavioural registered-read RAM.
module tb_scratchstack_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [1:0] OP_CLEAR = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_PEEK = 2'b11;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW:0]   depth;
    logic          empty, full;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wen;
    logic [DW-1:0] ram_rdata;

    scratchstack_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .depth(depth), .empty(empty),
        .full(full), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_rdata(ram_rdata)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [256];
    always @(posedge CLK) begin
        if (ram_wen) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            edge_n;
        logic          err;
        logic          rd;
        logic [DW-1:0] rdata;
        logic [AW:0]   depth;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    bit wen_forbid = 1'b0;
    int wen_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (wen_forbid && ram_wen) wen_seen++;
        if (!RST && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_latency_edge", 64'(cyc), 64'(e.edge_n));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_depth", 64'(depth), 64'(e.depth));
                if (e.rd) chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [DW-1:0] data, input bit sb,
                         input logic e_err, input logic [DW-1:0] e_rdata, input int e_depth);
        int n;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        if (sb) begin
            e.edge_n = cyc + 1 + ((op == OP_POP || op == OP_PEEK) ? 2 : 1);
            e.err    = e_err;
            e.rd     = (op == OP_POP || op == OP_PEEK);
            e.rdata  = e_rdata;
            e.depth  = (AW+1)'(e_depth);
            sbq.push_back(e);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("drain_timeout", 64'(sbq.size()), 0);
            sbq.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    logic [DW-1:0] hv [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};

    initial begin
        int acc;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("rst_cmd_ready", 64'(cmd_ready), 1);
        chk("rst_depth", 64'(depth), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
        chk("rst_ram_wen", 64'(ram_wen), 0);
        chk("rst_ram_addr", 64'(ram_addr), 0);

        // underflow after reset
        issue(OP_POP,  0, 1, 1'b1, 32'h0, 0);
        issue(OP_PEEK, 0, 1, 1'b1, 32'h0, 0);
        drain();

        // LIFO order
        issue(OP_PUSH, 32'h11, 1, 1'b0, 0, 1);
        issue(OP_PUSH, 32'h22, 1, 1'b0, 0, 2);
        issue(OP_PUSH, 32'h33, 1, 1'b0, 0, 3);
        issue(OP_POP,  0, 1, 1'b0, 32'h33, 2);
        issue(OP_POP,  0, 1, 1'b0, 32'h22, 1);
        issue(OP_POP,  0, 1, 1'b0, 32'h11, 0);
        drain();
        chk("lifo_empty", 64'(empty), 1);

        // PEEK / CLEAR
        issue(OP_PUSH,  32'hAB, 1, 1'b0, 0, 1);
        issue(OP_PEEK,  0, 1, 1'b0, 32'hAB, 1);
        issue(OP_PEEK,  0, 1, 1'b0, 32'hAB, 1);
        issue(OP_CLEAR, 0, 1, 1'b0, 0, 0);
        issue(OP_POP,   0, 1, 1'b1, 32'h0, 0);
        drain();
        chk("clear_empty", 64'(empty), 1);

        // fill to capacity, then overflow
        for (int i = 0; i < 256; i++) issue(OP_PUSH, DW'(i), 1, 1'b0, 0, i + 1);
        drain();
        chk("fill_full", 64'(full), 1);
        chk("fill_depth", 64'(depth), 256);
        wen_forbid = 1'b1;
        issue(OP_PUSH, 32'hDEAD, 1, 1'b1, 0, 256);
        drain();
        wen_forbid = 1'b0;
        chk("overflow_no_wen", 64'(wen_seen), 0);
        issue(OP_POP, 0, 1, 1'b0, 32'd255, 255);
        drain();
        chk("after_pop_full", 64'(full), 0);
        issue(OP_CLEAR, 0, 1, 1'b0, 0, 0);
        drain();

        // reset during a POP
        issue(OP_PUSH, 32'h01, 1, 1'b0, 0, 1);
        issue(OP_PUSH, 32'h02, 1, 1'b0, 0, 2);
        drain();
        issue(OP_POP, 0, 0, 1'b0, 0, 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midpop_depth", 64'(depth), 0);
        chk("midpop_ready", 64'(cmd_ready), 1);
        chk("midpop_rsp_valid", 64'(rsp_valid), 0);
        repeat (4) @(negedge CLK);

        // reset during WR: the write still lands in the RAM
        issue(OP_PUSH, 32'h55, 0, 1'b0, 0, 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midwr_depth", 64'(depth), 0);
        chk("midwr_mem0", 64'(mem[0]), 64'h55);
        issue(OP_PUSH, 32'h66, 1, 1'b0, 0, 1);
        issue(OP_PEEK, 0, 1, 1'b0, 32'h66, 1);
        issue(OP_CLEAR, 0, 1, 1'b0, 0, 0);
        drain();

        // held cmd_valid: accepts every other cycle, each with its own data
        acc = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        for (int i = 0; i < 6; i++) begin
            cmd_wdata = hv[i];
            chk("hold_ready", 64'(cmd_ready), 64'((i % 2) == 0));
            if (cmd_ready) begin
                exp_t e;
                acc++;
                e.edge_n = cyc + 2;
                e.err = 1'b0; e.rd = 1'b0; e.rdata = '0; e.depth = (AW+1)'(acc);
                sbq.push_back(e);
            end
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        chk("hold_accepts", 64'(acc), 3);
        issue(OP_POP, 0, 1, 1'b0, 32'hA4, 2);
        issue(OP_POP, 0, 1, 1'b0, 32'hA2, 1);
        issue(OP_POP, 0, 1, 1'b0, 32'hA0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
